line_rd_responder: RTL and testbench

- Responder end of the data-cache line-read request interface: accepts one request at a time from the upstream prefetch buffer, runs the AXI4 read, and returns data.
- A cached request (rd_type=1) reads 32 bytes: the demanded 16B line plus the next sequential line, returned packed as ret_data[255:0].
- An uncached request (rd_type=0) reads one 32-bit word.
- Sits between the prefetcher and the AXI interconnect. Single outstanding transaction.

---
 rtl/line_rd_responder_pkg.sv | 25 ++
 rtl/line_rd_responder_if.sv | 36 +++
 rtl/line_rd_responder.sv | 125 ++++++++++++
 tb/tb_line_rd_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_rd_responder_pkg.sv
// Shared types and AXI read constants for the data-cache line-read responder.
package line_rd_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RET  = 2'd3
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [7:0] LEN_LINE2  = 8'd7;
  localparam logic [7:0] LEN_HALF   = 8'd3;
  localparam logic [7:0] LEN_WORD   = 8'd0;

  localparam logic RD_TYPE_CACHED   = 1'b1;
  localparam logic RD_TYPE_UNCACHED = 1'b0;

  // Base line index FF within a 4KB page means the following line is in the next page.
  function automatic logic crosses_4k(input logic [7:0] line_idx);
    return line_idx == 8'hFF;
  endfunction

endpackage

// File: rtl/line_rd_responder_if.sv
// Upstream line-read request bus plus AXI4 read channels seen by the responder.
interface line_rd_responder_if;
  logic         rd_req;
  logic         rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [255:0] ret_data;
  logic         rd_err;

  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  modport slave (
    input  rd_req, rd_type, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    output rd_rdy, ret_valid, ret_data, rd_err,
           arid, araddr, arlen, arsize, arburst, arvalid, rready
  );

  modport master (
    output rd_req, rd_type, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    input  rd_rdy, ret_valid, ret_data, rd_err,
           arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/line_rd_responder.sv
// Single-outstanding AXI4 line-read responder: cached 32B (two lines) or uncached word.
// Optional macro LINE_RD_RRESP_CHECK_EN enables a sticky per-request rd_err from rresp[1].
module line_rd_responder
  import line_rd_responder_pkg::*;
#(
  parameter logic [3:0]  ARID_VAL = 4'd1,
  parameter int unsigned SPLIT_4K = 1
) (
  input  logic               clk,
  input  logic               resetn,
  line_rd_responder_if.slave bus
);

  state_e        state_q, state_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [7:0]    arlen_q, arlen_d;
  logic          split_q, split_d;
  logic [2:0]    beat_q, beat_d;
  logic [255:0]  data_q, data_d;
  logic [31:0]   base_addr;
  logic          cached_req;
  logic          do_split;

  assign cached_req = (bus.rd_type == RD_TYPE_CACHED);
  assign base_addr  = {bus.rd_addr[31:4], 4'b0};
  assign do_split   = cached_req && (SPLIT_4K != 0) && crosses_4k(base_addr[11:4]);

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    split_d  = split_q;
    beat_d   = beat_q;
    data_d   = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.rd_req) begin
          araddr_d = cached_req ? base_addr : bus.rd_addr;
          arlen_d  = !cached_req ? LEN_WORD : (do_split ? LEN_HALF : LEN_LINE2);
          split_d  = do_split;
          beat_d   = '0;
          data_d   = '0;
          state_d  = ST_AR;
        end
      end
      ST_AR: begin
        if (bus.arready) state_d = ST_R;
      end
      ST_R: begin
        if (bus.rvalid) begin
          data_d[{beat_q, 5'd0} +: 32] = bus.rdata;
          beat_d = beat_q + 3'd1;
          if (bus.rlast) begin
            // First half of a split: reissue AR for the next line; beat_cnt keeps counting.
            if (split_q) begin
              split_d  = 1'b0;
              araddr_d = araddr_q + 32'd16;
              state_d  = ST_AR;
            end else begin
              state_d  = ST_RET;
            end
          end
        end
      end
      ST_RET: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      split_q  <= 1'b0;
      beat_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      split_q  <= split_d;
      beat_q   <= beat_d;
      data_q   <= data_d;
    end
  end

  assign bus.rd_rdy    = (state_q == ST_IDLE);
  assign bus.arvalid   = (state_q == ST_AR);
  assign bus.rready    = (state_q == ST_R);
  assign bus.ret_valid = (state_q == ST_RET);
  assign bus.ret_data  = data_q;
  assign bus.arid      = ARID_VAL;
  assign bus.araddr    = araddr_q;
  assign bus.arlen     = arlen_q;
  assign bus.arsize    = SIZE_4B;
  assign bus.arburst   = BURST_INCR;

`ifdef LINE_RD_RRESP_CHECK_EN
  logic err_q, err_d;
  logic unused_in;

  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && bus.rd_req) begin
      err_d = 1'b0;
    end else if (state_q == ST_R && bus.rvalid && bus.rresp[1]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign bus.rd_err = err_q;
  assign unused_in  = ^{bus.rid, bus.rresp[0]};
`else
  logic unused_in;
  assign bus.rd_err = 1'b0;
  assign unused_in  = ^{bus.rid, bus.rresp};
`endif

endmodule

// File: tb/tb_line_rd_responder.sv
// Scoreboard bench for line_rd_responder: driver pushes expected AR/return items, monitor pops.
module tb_line_rd_responder;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef LINE_RD_RRESP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  line_rd_responder_if bus();

  line_rd_responder #(.ARID_VAL(4'd5), .SPLIT_4K(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [255:0] data; logic err; int lat; } ret_t;
  ar_t  ar_q[$];
  ret_t ret_q[$];

  logic [31:0] words [8];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: AR handshakes, AR stability under backpressure, and return pulses.
  int          accept_cyc = 0;
  logic        ar_hold = 1'b0;
  logic [31:0] hold_addr;
  logic [7:0]  hold_len;
  logic        last_ret = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      ar_hold  = 1'b0;
      last_ret = 1'b0;
    end else begin
      if (bus.rd_req && bus.rd_rdy) accept_cyc = cyc;
      if (bus.arvalid) begin
        if (ar_hold) begin
          chk("ar_stable_addr", {224'b0, bus.araddr}, {224'b0, hold_addr});
          chk("ar_stable_len", {248'b0, bus.arlen}, {248'b0, hold_len});
        end
        if (bus.arready) begin
          ar_hold = 1'b0;
          if (ar_q.size() == 0) begin
            chk("ar_unexpected", 256'd1, 256'd0);
          end else begin
            ar_t e;
            e = ar_q.pop_front();
            chk("araddr", {224'b0, bus.araddr}, {224'b0, e.addr});
            chk("arlen", {248'b0, bus.arlen}, {248'b0, e.len});
            chk("ar_const", {247'b0, bus.arid, bus.arsize, bus.arburst},
                {247'b0, 4'd5, 3'b010, 2'b01});
          end
        end else begin
          ar_hold   = 1'b1;
          hold_addr = bus.araddr;
          hold_len  = bus.arlen;
        end
      end
      if (bus.ret_valid) begin
        chk("ret_pulse", {255'b0, last_ret}, 256'd0);
        if (ret_q.size() == 0) begin
          chk("ret_unexpected", 256'd1, 256'd0);
        end else begin
          ret_t e;
          e = ret_q.pop_front();
          chk("ret_data", bus.ret_data, e.data);
          chk("rd_err", {255'b0, bus.rd_err}, {255'b0, e.err});
          if (e.lat >= 0) chk("latency", 256'(cyc - accept_cyc), 256'(e.lat));
        end
      end
      last_ret = bus.ret_valid;
    end
  end

  task automatic request(input logic typ, input logic [31:0] addr);
    bus.rd_req  = 1'b1;
    bus.rd_type = typ;
    bus.rd_addr = addr;
    tick;
    bus.rd_req  = 1'b0;
  endtask

  task automatic ar_phase(input int delay);
    int i;
    for (i = 0; i < 20 && !bus.arvalid; i++) tick;
    chk("ar_wait", {255'b0, bus.arvalid}, 256'd1);
    for (int d = 0; d < delay; d++) begin
      chk("rdy_low_ar", {255'b0, bus.rd_rdy}, 256'd0);
      tick;
    end
    bus.arready = 1'b1;
    tick;
    bus.arready = 1'b0;
  endtask

  task automatic r_beats(input int first, input int n, input bit gaps, input int errbeat,
                         input bit do_last);
    for (int b = 0; b < n; b++) begin
      if (gaps && (b % 2 == 1)) begin
        bus.rvalid = 1'b0;
        tick;
        chk("rdy_low_gap", {255'b0, bus.rd_rdy}, 256'd0);
      end
      chk("rready", {255'b0, bus.rready}, 256'd1);
      bus.rvalid = 1'b1;
      bus.rdata  = words[first + b];
      bus.rresp  = (first + b == errbeat) ? 2'b10 : 2'b00;
      bus.rlast  = do_last && (b == n - 1);
      tick;
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
  endtask

  task automatic wait_ret;
    for (int i = 0; i < 30 && ret_q.size() != 0; i++) tick;
    chk("ret_seen", 256'(ret_q.size()), 256'd0);
    tick;
  endtask

  function automatic logic [255:0] pack8();
    logic [255:0] v;
    for (int unsigned k = 0; k < 8; k++) v[k*32 +: 32] = words[k];
    return v;
  endfunction

  task automatic cached_test(input logic [31:0] addr, input logic [31:0] seed,
                             input int delay, input bit gaps, input int errbeat,
                             input logic exp_err, input int lat);
    for (int k = 0; k < 8; k++) words[k] = seed + 32'(k);
    ar_q.push_back('{addr: {addr[31:4], 4'b0}, len: 8'd7});
    ret_q.push_back('{data: pack8(), err: exp_err, lat: lat});
    request(1'b1, addr);
    ar_phase(delay);
    r_beats(0, 8, gaps, errbeat, 1'b1);
    wait_ret;
  endtask

  task automatic uncached_test(input logic [31:0] addr, input logic [31:0] w, input int lat);
    words[0] = w;
    ar_q.push_back('{addr: addr, len: 8'd0});
    ret_q.push_back('{data: {224'b0, w}, err: 1'b0, lat: lat});
    request(1'b0, addr);
    ar_phase(0);
    r_beats(0, 1, 1'b0, -1, 1'b1);
    wait_ret;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn      = 1'b0;
    bus.rd_req  = 1'b0;
    bus.rd_type = 1'b0;
    bus.rd_addr = '0;
    bus.arready = 1'b0;
    bus.rid     = '0;
    bus.rdata   = '0;
    bus.rresp   = '0;
    bus.rlast   = 1'b0;
    bus.rvalid  = 1'b0;
    #3;
    chk("rst_rd_rdy", {255'b0, bus.rd_rdy}, 256'd1);
    chk("rst_ret", {253'b0, bus.ret_valid, bus.arvalid, bus.rready}, 256'd0);
    chk("rst_ret_data", bus.ret_data, 256'd0);
    chk("rst_rd_err", {255'b0, bus.rd_err}, 256'd0);
    chk("rst_ar", {216'b0, bus.araddr, bus.arlen}, 256'd0);
    tick; tick;
    resetn = 1'b1;
    tick;

    cached_test(32'h1C001234, 32'h0, 0, 1'b0, -1, 1'b0, 10);
    uncached_test(32'hBFAF8004, 32'hDEADBEEF, 3);

    // 4KB split: two half bursts, one return pulse.
    for (int k = 0; k < 8; k++) words[k] = 32'h100 + 32'(k);
    ar_q.push_back('{addr: 32'h00000FF0, len: 8'd3});
    ar_q.push_back('{addr: 32'h00001000, len: 8'd3});
    ret_q.push_back('{data: pack8(), err: 1'b0, lat: -1});
    request(1'b1, 32'h00000FF8);
    ar_phase(0);
    r_beats(0, 4, 1'b0, -1, 1'b1);
    ar_phase(0);
    r_beats(4, 4, 1'b0, -1, 1'b1);
    wait_ret;

    // One line below the page end: no split.
    cached_test(32'h00000FE8, 32'h200, 0, 1'b0, -1, 1'b0, 10);

    // AR backpressure and rvalid gaps.
    cached_test(32'h20000044, 32'hA0, 5, 1'b1, -1, 1'b0, -1);

    // Error beat then a clean request.
    cached_test(32'h30000000, 32'h300, 0, 1'b0, 3, ERR_EN, 10);
    uncached_test(32'h30000010, 32'h0BADF00D, 3);

    // Reset during beat 4 of a cached burst.
    for (int k = 0; k < 8; k++) words[k] = 32'h400 + 32'(k);
    ar_q.push_back('{addr: 32'h40000000, len: 8'd7});
    request(1'b1, 32'h40000000);
    ar_phase(0);
    r_beats(0, 4, 1'b0, -1, 1'b0);
    bus.rvalid = 1'b1;
    bus.rdata  = words[4];
    #2;
    resetn = 1'b0;
    #1;
    bus.rvalid = 1'b0;
    chk("rst_mid_outs", {253'b0, bus.rready, bus.arvalid, bus.ret_valid}, 256'd0);
    chk("rst_mid_rdy", {255'b0, bus.rd_rdy}, 256'd1);
    tick;
    resetn = 1'b1;
    tick;
    chk("post_rst_rdy", {255'b0, bus.rd_rdy}, 256'd1);
    uncached_test(32'h50000008, 32'h12345678, 3);

    chk("ar_q_empty", 256'(ar_q.size()), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
